// File: rtl/banked_regfile_pkg.sv
// ============================================================================
// Module   : banked_regfile_pkg
// Brief    : Shared step codes, selector layout and reset defaults for the
//            banked register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package banked_regfile_pkg;

  typedef enum logic [1:0] {
    STEP_IDLE0  = 2'd0,
    STEP_DECODE = 2'd1,
    STEP_IDLE2  = 2'd2,
    STEP_COMMIT = 2'd3
  } step_e;

  // Selector layout is {bank, direct, index}; index occupies the low IDX_W bits.
  localparam int SEL_IDX_LSB = 0;

  function automatic int sel_direct_bit(input int idx_w);
    return idx_w;
  endfunction

  function automatic int sel_bank_bit(input int idx_w);
    return idx_w + 1;
  endfunction

  // Meaning of {bank, direct} when index is 0.
  localparam logic [1:0] SPECIAL_PC      = 2'b00;
  localparam logic [1:0] SPECIAL_ZERO    = 2'b01;
  localparam logic [1:0] SPECIAL_FLAGS   = 2'b10;
  localparam logic [1:0] SPECIAL_BANKING = 2'b11;

  localparam logic [15:0] BANKING_RESET_DEFAULT = 16'h00E0;

endpackage

`default_nettype wire

// File: rtl/regfile_sel_decode.sv
// ============================================================================
// Module   : regfile_sel_decode
// Brief    : Pure decoder from a {bank, direct, index} selector to its fields
//            and the special index-0 targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sel_decode
  import banked_regfile_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic [IDX_W+1:0] sel,
  output logic             is_pc,
  output logic             is_zero,
  output logic             is_flags,
  output logic             is_banking,
  output logic             bank,
  output logic             direct,
  output logic [IDX_W-1:0] idx
);

  logic       w_idx_zero;
  logic [1:0] w_mode;

  assign bank       = sel[sel_bank_bit(IDX_W)];
  assign direct     = sel[sel_direct_bit(IDX_W)];
  assign idx        = sel[SEL_IDX_LSB +: IDX_W];
  assign w_idx_zero = (idx == '0);
  assign w_mode     = {bank, direct};

  assign is_pc      = w_idx_zero && (w_mode == SPECIAL_PC);
  assign is_zero    = w_idx_zero && (w_mode == SPECIAL_ZERO);
  assign is_flags   = w_idx_zero && (w_mode == SPECIAL_FLAGS);
  assign is_banking = w_idx_zero && (w_mode == SPECIAL_BANKING);

endmodule

`default_nettype wire

// File: rtl/banked_register_file.sv
// ============================================================================
// Module   : banked_register_file
// Brief    : PC, flags, banking and normal/banked general registers with two
//            latched read selectors and one write port, sequenced by step.
//            Banked set enabled by defining BANKED_REGFILE_BANKING_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_register_file
  import banked_regfile_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               NUM_REGS      = 3,
  parameter logic [WIDTH-1:0] PC_RESET      = '0,
  parameter logic [WIDTH-1:0] BANKING_RESET = WIDTH'(BANKING_RESET_DEFAULT),
  parameter int               IDX_W         = $clog2(NUM_REGS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       step,
  input  logic [IDX_W+1:0] desired_source,
  input  logic [IDX_W+1:0] desired_destination,
  input  logic [WIDTH-1:0] write_value,
  input  logic             write_enable,
  input  logic             push,
  input  logic             pop,
  input  logic             inc_enable,
  input  logic [WIDTH-1:0] flags_in,
  input  logic             write_flags,
  output logic [WIDTH-1:0] source_value,
  output logic [WIDTH-1:0] destination_value,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] flags,
  output logic [WIDTH-1:0] banking,
  output logic             source_banked,
  output logic             destination_banked
);

`ifdef BANKED_REGFILE_BANKING_EN
  localparam int c_num_sets = 2;
`else
  localparam int c_num_sets = 1;
`endif
  localparam int               c_slots   = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] c_max_idx = IDX_W'(NUM_REGS);

  logic [IDX_W+1:0] r_src_sel;
  logic [IDX_W+1:0] r_dst_sel;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_gpr [c_num_sets][c_slots];

  logic             w_src_is_pc, w_src_is_zero, w_src_is_flags, w_src_is_banking;
  logic             w_src_bank, w_src_direct;
  logic [IDX_W-1:0] w_src_idx;
  logic             w_dst_is_pc, w_dst_is_zero, w_dst_is_flags, w_dst_is_banking;
  logic             w_dst_bank, w_dst_direct;
  logic [IDX_W-1:0] w_dst_idx;

  logic w_src_set, w_dst_set;
  logic w_src_gen, w_dst_gen;
  logic w_commit, w_wr_hit, w_push_hit, w_pop_hit;
  logic w_wr_sel   [c_num_sets][c_slots];
  logic w_push_sel [c_num_sets][c_slots];
  logic w_pop_sel  [c_num_sets][c_slots];
  logic [WIDTH-1:0] w_src_gpr, w_dst_gpr;

  regfile_sel_decode #(.IDX_W(IDX_W)) u_src_dec (
    .sel        (r_src_sel),
    .is_pc      (w_src_is_pc),
    .is_zero    (w_src_is_zero),
    .is_flags   (w_src_is_flags),
    .is_banking (w_src_is_banking),
    .bank       (w_src_bank),
    .direct     (w_src_direct),
    .idx        (w_src_idx)
  );

  regfile_sel_decode #(.IDX_W(IDX_W)) u_dst_dec (
    .sel        (r_dst_sel),
    .is_pc      (w_dst_is_pc),
    .is_zero    (w_dst_is_zero),
    .is_flags   (w_dst_is_flags),
    .is_banking (w_dst_is_banking),
    .bank       (w_dst_bank),
    .direct     (w_dst_direct),
    .idx        (w_dst_idx)
  );

`ifdef BANKED_REGFILE_BANKING_EN
  logic [WIDTH-1:0] r_banking;

  assign w_src_set          = w_src_bank;
  assign w_dst_set          = w_dst_bank;
  assign banking            = r_banking;
  assign source_banked      = w_src_bank && (w_src_idx != '0);
  assign destination_banked = w_dst_bank && (w_dst_idx != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_banking <= BANKING_RESET;
    end else if ((step == STEP_COMMIT) && write_enable && w_dst_is_banking) begin
      r_banking <= write_value;
    end
  end
`else
  // Single set: the bank bit only distinguishes special index-0 targets.
  logic w_unused_cfg;

  assign w_src_set          = 1'b0;
  assign w_dst_set          = 1'b0;
  assign banking            = '0;
  assign source_banked      = 1'b0;
  assign destination_banked = 1'b0;
  assign w_unused_cfg       = ^{w_src_bank, w_dst_bank, BANKING_RESET};
`endif

  assign w_src_gen  = (w_src_idx != '0) && (w_src_idx <= c_max_idx);
  assign w_dst_gen  = (w_dst_idx != '0) && (w_dst_idx <= c_max_idx);
  assign w_commit   = (step == STEP_COMMIT);
  assign w_wr_hit   = write_enable && w_dst_direct && w_dst_gen;
  assign w_push_hit = push && !w_dst_direct && w_dst_gen;
  assign w_pop_hit  = pop && !w_src_direct && w_src_gen;
  assign w_src_gpr  = r_gpr[w_src_set][w_src_idx];
  assign w_dst_gpr  = r_gpr[w_dst_set][w_dst_idx];

  always_comb begin
    for (int s = 0; s < c_num_sets; s++) begin
      for (int k = 0; k < c_slots; k++) begin
        w_wr_sel[s][k]   = w_wr_hit && (w_dst_set == 1'(s)) && (w_dst_idx == IDX_W'(k));
        w_push_sel[s][k] = w_push_hit && (w_dst_set == 1'(s)) && (w_dst_idx == IDX_W'(k));
        w_pop_sel[s][k]  = w_pop_hit && (w_src_set == 1'(s)) && (w_src_idx == IDX_W'(k));
      end
    end
  end

  always_comb begin
    source_value = '0;
    if (w_src_is_pc)           source_value = r_pc;
    else if (w_src_is_zero)    source_value = '0;
    else if (w_src_is_flags)   source_value = r_flags;
    else if (w_src_is_banking) source_value = banking;
    else if (w_src_gen)        source_value = w_src_gpr;
  end

  always_comb begin
    destination_value = '0;
    if (w_dst_is_pc)           destination_value = r_pc;
    else if (w_dst_is_zero)    destination_value = '0;
    else if (w_dst_is_flags)   destination_value = r_flags;
    else if (w_dst_is_banking) destination_value = banking;
    else if (w_dst_gen)        destination_value = w_dst_gpr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= PC_RESET;
      r_flags   <= '0;
      r_src_sel <= '0;
      r_dst_sel <= '0;
      for (int s = 0; s < c_num_sets; s++) begin
        for (int k = 1; k <= NUM_REGS; k++) begin
          r_gpr[s][k] <= '0;
        end
      end
    end else begin
      if (step == STEP_DECODE) begin
        r_src_sel <= desired_source;
        r_dst_sel <= desired_destination;
      end
      if (w_commit) begin
        if (write_flags)                          r_flags <= flags_in;
        else if (write_enable && w_dst_is_flags)  r_flags <= write_value;
        if (write_enable && w_dst_is_pc)          r_pc <= write_value;
        else if (inc_enable)                      r_pc <= r_pc + WIDTH'(1);
        // A direct write wins; a simultaneous push and pop on one pointer cancel.
        for (int s = 0; s < c_num_sets; s++) begin
          for (int k = 1; k <= NUM_REGS; k++) begin
            if (w_wr_sel[s][k])
              r_gpr[s][k] <= write_value;
            else if (w_push_sel[s][k] && !w_pop_sel[s][k])
              r_gpr[s][k] <= r_gpr[s][k] - WIDTH'(1);
            else if (w_pop_sel[s][k] && !w_push_sel[s][k])
              r_gpr[s][k] <= r_gpr[s][k] + WIDTH'(1);
          end
        end
      end
    end
  end

  assign pc    = r_pc;
  assign flags = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_banked_register_file.sv
// ============================================================================
// Module   : tb_banked_register_file
// Brief    : Self-checking bench: directed scenarios plus random steps against
//            a behavioural model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_register_file;

`ifdef BANKED_REGFILE_BANKING_EN
  localparam bit c_bank_en = 1'b1;
`else
  localparam bit c_bank_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  step;
  logic [3:0]  desired_source, desired_destination;
  logic [15:0] write_value, flags_in;
  logic        write_enable, push, pop, inc_enable, write_flags;
  logic [15:0] source_value, destination_value, pc, flags, banking;
  logic        source_banked, destination_banked;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [15:0] m_pc, m_flags, m_bank;
  logic [15:0] m_regs [2][4];
  logic [3:0]  m_src, m_dst;

  always #5 clk = ~clk;

  banked_register_file u_dut (
    .clock               (clk),
    .reset               (rst),
    .step                (step),
    .desired_source      (desired_source),
    .desired_destination (desired_destination),
    .write_value         (write_value),
    .write_enable        (write_enable),
    .push                (push),
    .pop                 (pop),
    .inc_enable          (inc_enable),
    .flags_in            (flags_in),
    .write_flags         (write_flags),
    .source_value        (source_value),
    .destination_value   (destination_value),
    .pc                  (pc),
    .flags               (flags),
    .banking             (banking),
    .source_banked       (source_banked),
    .destination_banked  (destination_banked)
  );

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int set_of(input logic [3:0] sel);
    return (c_bank_en && sel[3]) ? 1 : 0;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] sel);
    if (sel[1:0] == 2'd0) begin
      case (sel[3:2])
        2'b00:   return m_pc;
        2'b01:   return 16'h0000;
        2'b10:   return m_flags;
        default: return m_bank;
      endcase
    end
    return m_regs[set_of(sel)][sel[1:0]];
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_flags = 16'h0000; m_src = 4'h0; m_dst = 4'h0;
    m_bank = c_bank_en ? 16'h00E0 : 16'h0000;
    for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) m_regs[s][k] = 16'h0000;
  endtask

  task automatic model_commit();
    int          delta [2][4];
    logic [15:0] nxt [2][4];
    for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) delta[s][k] = 0;
    if (push && !m_dst[2] && m_dst[1:0] != 2'd0) delta[set_of(m_dst)][m_dst[1:0]] -= 1;
    if (pop && !m_src[2] && m_src[1:0] != 2'd0)  delta[set_of(m_src)][m_src[1:0]] += 1;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++) nxt[s][k] = m_regs[s][k] + 16'(delta[s][k]);
    if (write_enable && m_dst[2] && m_dst[1:0] != 2'd0) nxt[set_of(m_dst)][m_dst[1:0]] = write_value;
    m_regs = nxt;
    if (write_flags) m_flags = flags_in;
    else if (write_enable && m_dst == 4'b1000) m_flags = write_value;
    if (write_enable && m_dst == 4'b0000) m_pc = write_value;
    else if (inc_enable) m_pc = m_pc + 16'd1;
    if (c_bank_en && write_enable && m_dst == 4'b1100) m_bank = write_value;
  endtask

  // Apply one clock of stimulus, advance the model, then compare all outputs.
  task automatic cycle(input logic [1:0] st, input logic [3:0] src, input logic [3:0] dst,
                       input logic [15:0] wv, input logic we, input logic ps, input logic pp,
                       input logic inc, input logic [15:0] fin, input logic wf, input logic r);
    step = st; desired_source = src; desired_destination = dst; write_value = wv;
    write_enable = we; push = ps; pop = pp; inc_enable = inc; flags_in = fin;
    write_flags = wf; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else if (st == 2'd1) begin m_src = src; m_dst = dst; end
    else if (st == 2'd3) model_commit();
    #1;
    check_value("source_value", source_value, m_read(m_src));
    check_value("destination_value", destination_value, m_read(m_dst));
    check_value("pc", pc, m_pc);
    check_value("flags", flags, m_flags);
    check_value("banking", banking, m_bank);
    check_value("source_banked", {15'd0, source_banked}, {15'd0, c_bank_en && m_src[3] && m_src[1:0] != 2'd0});
    check_value("destination_banked", {15'd0, destination_banked}, {15'd0, c_bank_en && m_dst[3] && m_dst[1:0] != 2'd0});
  endtask

  task automatic dec(input logic [3:0] src, input logic [3:0] dst);
    cycle(2'd1, src, dst, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic com(input logic [15:0] wv, input logic we, input logic ps, input logic pp,
                     input logic inc, input logic [15:0] fin, input logic wf);
    cycle(2'd3, 4'h0, 4'h0, wv, we, ps, pp, inc, fin, wf, 0);
  endtask

  initial begin
    model_reset();
    cycle(2'd3, 4'hD, 4'h5, 16'hABCD, 1, 1, 1, 1, 16'h1234, 1, 1);
    cycle(2'd0, 4'h0, 4'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 1);
    check_value("reset_pc", pc, 16'h0000);
    check_value("reset_banking", banking, c_bank_en ? 16'h00E0 : 16'h0000);
    dec(4'h0, 4'h0);
    check_value("reset_src", source_value, 16'h0000);
    check_value("reset_dst", destination_value, 16'h0000);

    com(16'hFFFF, 1, 0, 0, 0, 16'h0, 0);
    check_value("pc_write", pc, 16'hFFFF);
    com(16'h0, 0, 0, 0, 1, 16'h0, 0);
    check_value("pc_wrap", pc, 16'h0000);

    dec(4'h0, 4'h5); com(16'hFFF1, 1, 0, 0, 0, 16'h0, 0);
    dec(4'h0, 4'h1); com(16'h5555, 1, 0, 0, 0, 16'h0, 0);
    check_value("r1_mem_write_ignored", destination_value, 16'hFFF1);
    dec(4'h0, 4'hD); com(16'hFFF9, 1, 0, 0, 0, 16'h0, 0);
    dec(4'h0, 4'h9); com(16'h5555, 1, 0, 0, 0, 16'h0, 0);
    check_value("rb1_mem_write_ignored", destination_value, 16'hFFF9);
    dec(4'h5, 4'h0);
    check_value("r1_after_rb1", source_value, c_bank_en ? 16'hFFF1 : 16'hFFF9);

    dec(4'h0, 4'h8); com(16'h5555, 1, 0, 0, 0, 16'hFF00, 1);
    check_value("flags_priority", flags, 16'hFF00);
    com(16'h5555, 1, 0, 0, 0, 16'hFF00, 0);
    check_value("flags_write", flags, 16'h5555);

    dec(4'h0, 4'h6); com(16'h0010, 1, 0, 0, 0, 16'h0, 0);
    dec(4'h0, 4'h2); com(16'h0, 0, 1, 0, 0, 16'h0, 0);
    check_value("push_r2", destination_value, 16'h000F);
    dec(4'h0, 4'h6); com(16'h0010, 1, 0, 0, 0, 16'h0, 0);
    dec(4'h2, 4'h0); com(16'h0, 0, 0, 1, 0, 16'h0, 0);
    check_value("pop_r2", source_value, 16'h0011);
    dec(4'h0, 4'h6); com(16'h0010, 1, 0, 0, 0, 16'h0, 0);
    dec(4'h2, 4'h2); com(16'h0, 0, 1, 1, 0, 16'h0, 0);
    check_value("push_pop_r2", source_value, 16'h0010);
    dec(4'h0, 4'h3); com(16'h0, 0, 1, 0, 0, 16'h0, 0);
    check_value("push_r3_wrap", destination_value, 16'hFFFF);

    dec(4'h0, 4'hD); com(16'h1234, 1, 0, 0, 0, 16'h0, 0);
    dec(4'h5, 4'hC); com(16'hBEEF, 1, 0, 0, 0, 16'h0, 0);
    check_value("r1_alias", source_value, c_bank_en ? 16'hFFF1 : 16'h1234);
    check_value("banking_write", banking, c_bank_en ? 16'hBEEF : 16'h0000);
    cycle(2'd0, 4'h1, 4'h2, 16'h7777, 1, 1, 1, 1, 16'h7777, 1, 0);
    cycle(2'd2, 4'h1, 4'h2, 16'h7777, 1, 1, 1, 1, 16'h7777, 1, 0);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] wv;
      case ($urandom_range(0, 3))
        0:       wv = 16'hFFFF;
        1:       wv = 16'h0000;
        default: wv = 16'($urandom);
      endcase
      cycle(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            wv, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/banked_register_file.md
# banked_register_file

Parametrised CPU register file: the next generation of the 16-bit `register_block`. It holds the PC, a configurable number of general registers in normal and banked sets, flags, and a banking register. Two read ports and one write port are sequenced by the 2-bit instruction `step`, with push/pop pointer adjust and PC increment. It sits between instruction decode and the ALU/memory datapath in the uCISC core.

## Interface
- WIDTH, 16, data width of every register
- NUM_REGS, 3, general registers per set (rN and rbN); IDX_W = $clog2(NUM_REGS+1)
- PC_RESET, 0, PC value after reset
- BANKING_RESET, 16'h00E0 (zero-extended/truncated to WIDTH), banking register value after reset
- clock  in  1  the only clock, rising edge
- reset  in  1  synchronous, active-high
- step  in  2  instruction phase; 1 = decode, 3 = commit, 0 and 2 = idle
- desired_source  in  IDX_W+2  source selector {bank, direct, index}
- desired_destination  in  IDX_W+2  destination selector, same encoding
- write_value  in  WIDTH  data for destination write
- write_enable  in  1  commit write_value to destination at step 3
- push  in  1  pre-decrement the destination pointer register at step 3
- pop  in  1  post-increment the source pointer register at step 3
- inc_enable  in  1  increment PC at step 3
- flags_in  in  WIDTH  ALU flags
- write_flags  in  1  load flags_in at step 3
- source_value  out  WIDTH  value of the latched source selection
- destination_value  out  WIDTH  value of the latched destination selection
- pc, flags, banking  out  WIDTH  live register contents
- source_banked, destination_banked  out  1  latched selection addresses a banked register

## Operation
- Selector decode: index 0 with {bank,direct} = 00 → PC; 01 → constant 0 (value slot); 10 → flags; 11 → banking. Index k>0: bank selects rN/rbN; direct=1 means register operand, direct=0 means memory-pointer use.
- Index values above NUM_REGS read 0 and ignore writes.
- Posedge with step==1: latch both selectors. Outputs are combinational from the latched selectors and current register contents.
- Posedge with step==3 applies, in priority order:
  - flags: write_flags loads flags_in. Otherwise, write_enable with a flags destination loads write_value.
  - PC: write_enable with a PC destination loads write_value. Otherwise, inc_enable adds 1 modulo 2^WIDTH.
  - rN/rbN: write_enable with direct=1 loads write_value. Writes with direct=0 are ignored; memory handles them.
  - push decrements the destination pointer register and pop increments the source pointer register, both only when direct=0. If both target the same register, it is unchanged. A direct write to that register overrides both.
  - Banking is writable only by direct=1, index 0, bank=1.
- *_banked = latched bank bit AND index≠0.
- Reset: PC=PC_RESET, banking=BANKING_RESET, all else 0, latched selectors 0, so every output reads PC. Reset wins over any step activity.

## Timing
- One-cycle selector latency: a value latched at step 1 is visible after that edge.
- Writes become visible on source/destination outputs after the step 3 edge, with no bypass.
- All arithmetic wraps: PC 0xFFFF+1 → 0x0000, pointer 0x0000−1 → 0xFFFF.
- Steps 0 and 2 modify nothing.

## Configuration
- BANKED_REGFILE_BANKING_EN defined: as above.
- BANKED_REGFILE_BANKING_EN undefined:
  - banking reads 0 and writes to it are ignored.
  - The bank bit is ignored for index>0: rbN aliases rN and only one set is instantiated.
  - *_banked outputs are tied to 0.

## Structure
- banked_regfile_pkg: step encodings (STEP_DECODE=1, STEP_COMMIT=3), selector field offsets, special-index codes, default BANKING_RESET.
- Sub-module regfile_sel_decode: a pure decoder from selector to {is_pc, is_zero, is_flags, is_banking, bank, direct, idx}. It is instantiated twice.

## Test plan
- Reset, then step 1 with selectors 0 → pc=0000, banking=00E0, source_value=destination_value=0000.
- Step 3, dest PC, write FFFF → pc=FFFF. Next step 3 with inc_enable and no write → pc=0000 (wrap).
- Dest r1 direct (sel 5) write FFF1, then dest r1 memory (sel 1) write 5555 → r1 stays FFF1; destination_banked=0. Repeat for rb1 (sel D/9) with FFF9 → destination_banked=1.
- Dest flags, write_enable with write_value 5555 plus write_flags with flags_in FF00 → flags=FF00. Without write_flags → flags=5555.
- r2=0010; push to dest 2 → 000F. Pop source 2 → 0011. Push and pop on r2 together → 0010 unchanged. Push on r3=0000 → FFFF.
- Macro undefined: write rb1 (sel D) with 1234 → r1 reads 1234, banking=0000, *_banked=0.
